// File: rtl/cmd_ximm_issue_queues_pkg.sv
// Shared widths and depths for the command / ximm1 issue queues.
package cmd_ximm_issue_queues_pkg;
  localparam int CMD_W       = 32;
  localparam int XIMM_W      = 64;
  localparam int CMDQ_DEPTH  = 4;
  localparam int XIMMQ_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/cmd_ximm_issue_queues_if.sv
// Decoder-side issue bus plus the two back-end drain ports.
interface cmd_ximm_issue_queues_if;
  import cmd_ximm_issue_queues_pkg::*;

  logic                          io_valid;
  logic                          io_sigs_enq_cmdq;
  logic                          io_sigs_enq_ximm1q;
  logic [CMD_W-1:0]              io_cmd;
  logic [XIMM_W-1:0]             io_ximm1;
  logic                          io_replay;
  logic                          io_cmdq_deq_valid;
  logic                          io_cmdq_deq_ready;
  logic [CMD_W-1:0]              io_cmdq_deq_bits;
  logic                          io_ximm1q_deq_valid;
  logic                          io_ximm1q_deq_ready;
  logic [XIMM_W-1:0]             io_ximm1q_deq_bits;
  logic [ptr_w(CMDQ_DEPTH):0]    io_cmdq_count;
  logic [ptr_w(XIMMQ_DEPTH):0]   io_ximm1q_count;

  modport master (
    output io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q, io_cmd, io_ximm1,
           io_cmdq_deq_ready, io_ximm1q_deq_ready,
    input  io_replay, io_cmdq_deq_valid, io_cmdq_deq_bits,
           io_ximm1q_deq_valid, io_ximm1q_deq_bits, io_cmdq_count, io_ximm1q_count
  );

  modport slave (
    input  io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q, io_cmd, io_ximm1,
           io_cmdq_deq_ready, io_ximm1q_deq_ready,
    output io_replay, io_cmdq_deq_valid, io_cmdq_deq_bits,
           io_ximm1q_deq_valid, io_ximm1q_deq_bits, io_cmdq_count, io_ximm1q_count
  );
endinterface

// File: rtl/cmd_ximm_issue_queues_issue_fifo.sv
// Circular-buffer FIFO with head/tail pointers and a maybe_full bit; no flow-through.
module issue_fifo
  import cmd_ximm_issue_queues_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [WIDTH-1:0]        enq_bits,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [WIDTH-1:0]        deq_bits,
  output logic [ptr_w(DEPTH):0]   count
);
  localparam int PW = ptr_w(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
  logic                        mf_q, mf_d;
  logic                        ptr_match, empty, full, do_enq, do_deq;

  assign ptr_match = (head_q == tail_q);
  assign empty     = ptr_match & ~mf_q;
  assign full      = ptr_match & mf_q;
  // Ready looks only at registered state, so a same-cycle deq never frees a slot.
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign deq_bits  = mem_q[head_q];
  assign do_enq    = enq_valid & enq_ready;
  assign do_deq    = deq_valid & deq_ready;
  // When full the pointer difference wraps to zero, so the MSB alone encodes DEPTH.
  assign count     = {full, tail_q - head_q};

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    mf_d   = mf_q;
    if (do_enq) tail_d = tail_q + PW'(1);
    if (do_deq) head_d = head_q + PW'(1);
    if (do_enq != do_deq) mf_d = do_enq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      mf_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      mf_q   <= mf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_enq) mem_q[tail_q] <= enq_bits;
  end
endmodule

// File: rtl/cmd_ximm_issue_queues.sv
// Atomic dual-queue issue stage: replays the instruction if any required queue is full.
module cmd_ximm_issue_queues
  import cmd_ximm_issue_queues_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  cmd_ximm_issue_queues_if.slave  io
);
  logic cmdq_ready, ximm1q_ready, replay, fire;

  assign replay = io.io_valid & ((io.io_sigs_enq_cmdq   & ~cmdq_ready) |
                                 (io.io_sigs_enq_ximm1q & ~ximm1q_ready));
  assign fire         = io.io_valid & ~replay;
  assign io.io_replay = replay;

  issue_fifo #(.WIDTH(CMD_W), .DEPTH(CMDQ_DEPTH)) u_cmdq (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (fire & io.io_sigs_enq_cmdq),
    .enq_ready (cmdq_ready),
    .enq_bits  (io.io_cmd),
    .deq_valid (io.io_cmdq_deq_valid),
    .deq_ready (io.io_cmdq_deq_ready),
    .deq_bits  (io.io_cmdq_deq_bits),
    .count     (io.io_cmdq_count)
  );

  issue_fifo #(.WIDTH(XIMM_W), .DEPTH(XIMMQ_DEPTH)) u_ximm1q (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (fire & io.io_sigs_enq_ximm1q),
    .enq_ready (ximm1q_ready),
    .enq_bits  (io.io_ximm1),
    .deq_valid (io.io_ximm1q_deq_valid),
    .deq_ready (io.io_ximm1q_deq_ready),
    .deq_bits  (io.io_ximm1q_deq_bits),
    .count     (io.io_ximm1q_count)
  );
endmodule

// File: tb/tb_cmd_ximm_issue_queues.sv
// Bench for cmd_ximm_issue_queues: queue-based reference model plus directed scenarios.
module tb_cmd_ximm_issue_queues;
  import cmd_ximm_issue_queues_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmd_ximm_issue_queues_if bus ();
  cmd_ximm_issue_queues dut (.clk(clk), .reset(reset), .io(bus));

  int errors = 0;
  int checks = 0;

  logic [CMD_W-1:0]  cq[$];
  logic [XIMM_W-1:0] xq[$];
  bit model_ok = 0;

  logic        s_replay, s_cvalid, s_xvalid, s_cfire;
  logic [31:0] s_cbits;
  logic [63:0] s_xbits;
  int          s_ccount, s_xcount;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_replay();
    return bus.io_valid && ((bus.io_sigs_enq_cmdq && cq.size() == CMDQ_DEPTH) ||
                            (bus.io_sigs_enq_ximm1q && xq.size() == XIMMQ_DEPTH));
  endfunction

  task automatic compare();
    s_replay = bus.io_replay;
    s_cvalid = bus.io_cmdq_deq_valid;
    s_xvalid = bus.io_ximm1q_deq_valid;
    s_cbits  = bus.io_cmdq_deq_bits;
    s_xbits  = bus.io_ximm1q_deq_bits;
    s_ccount = int'(bus.io_cmdq_count);
    s_xcount = int'(bus.io_ximm1q_count);
    s_cfire  = bus.io_cmdq_deq_valid & bus.io_cmdq_deq_ready;
    if (model_ok) begin
      chk("replay", 64'(s_replay), 64'(exp_replay()));
      chk("cmdq_valid", 64'(s_cvalid), 64'(cq.size() > 0));
      chk("ximm1q_valid", 64'(s_xvalid), 64'(xq.size() > 0));
      chk("cmdq_count", 64'(s_ccount), 64'(cq.size()));
      chk("ximm1q_count", 64'(s_xcount), 64'(xq.size()));
      if (cq.size() > 0) chk("cmdq_bits", 64'(s_cbits), 64'(cq[0]));
      if (xq.size() > 0) chk("ximm1q_bits", s_xbits, xq[0]);
    end
  endtask

  task automatic model_update();
    logic [CMD_W-1:0]  tc;
    logic [XIMM_W-1:0] tx;
    bit rep, cdq, xdq;
    if (reset) begin
      cq.delete();
      xq.delete();
      model_ok = 1;
    end else if (model_ok) begin
      rep = exp_replay();
      cdq = cq.size() > 0 && bus.io_cmdq_deq_ready;
      xdq = xq.size() > 0 && bus.io_ximm1q_deq_ready;
      if (cdq) tc = cq.pop_front();
      if (xdq) tx = xq.pop_front();
      if (bus.io_valid && !rep) begin
        if (bus.io_sigs_enq_cmdq)   cq.push_back(bus.io_cmd);
        if (bus.io_sigs_enq_ximm1q) xq.push_back(bus.io_ximm1);
      end
    end
  endtask

  // One cycle: compare outputs mid-cycle, advance the model, then let the DUT clock.
  task automatic step();
    @(negedge clk);
    compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit ec, input bit ex,
                       input logic [31:0] c, input logic [63:0] x);
    bus.io_valid = v;
    bus.io_sigs_enq_cmdq = ec;
    bus.io_sigs_enq_ximm1q = ex;
    bus.io_cmd = c;
    bus.io_ximm1 = x;
  endtask

  initial begin
    int got[$];
    int idx;
    reset = 1'b1;
    drive(0, 0, 0, '0, '0);
    bus.io_cmdq_deq_ready = 1'b0;
    bus.io_ximm1q_deq_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    step();
    chk("rst_cvalid", 64'(s_cvalid), 64'd0);
    chk("rst_ccount", 64'(s_ccount), 64'd0);

    // Post-reset issue
    drive(1, 1, 1, 32'h11, 64'h22);
    step();
    chk("issue_replay", 64'(s_replay), 64'd0);
    drive(0, 0, 0, '0, '0);
    step();
    chk("issue_cbits", 64'(s_cbits), 64'h11);
    chk("issue_xbits", s_xbits, 64'h22);
    chk("issue_counts", 64'({s_ccount[7:0], s_xcount[7:0]}), 64'h0101);

    // Atomicity: ximm1q full blocks a dual enqueue entirely
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, '0, 64'(32'h100 + i));
      step();
    end
    drive(1, 1, 1, 32'hAA, 64'hAA);
    step();
    chk("atom_replay", 64'(s_replay), 64'd1);
    drive(0, 0, 0, '0, '0);
    step();
    chk("atom_ccount", 64'(s_ccount), 64'd1);
    chk("atom_xcount", 64'(s_xcount), 64'd4);

    // Non-blocking queue and no-op
    drive(1, 1, 0, 32'hBB, '0);
    step();
    chk("cmdonly_replay", 64'(s_replay), 64'd0);
    drive(1, 0, 0, '0, '0);
    step();
    chk("noop_replay", 64'(s_replay), 64'd0);
    chk("cmdonly_ccount", 64'(s_ccount), 64'd2);
    drive(0, 0, 0, '0, '0);
    step();
    chk("noop_counts", 64'({s_ccount[7:0], s_xcount[7:0]}), 64'h0204);

    // Full cmdq with same-cycle drain still replays
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 32'hC0 + 32'(i), '0);
      step();
    end
    drive(1, 1, 0, 32'hCC, '0);
    bus.io_cmdq_deq_ready = 1'b1;
    step();
    chk("fulldrain_replay", 64'(s_replay), 64'd1);
    chk("fulldrain_cnt4", 64'(s_ccount), 64'd4);
    bus.io_cmdq_deq_ready = 1'b0;
    step();
    chk("fulldrain_cnt3", 64'(s_ccount), 64'd3);
    chk("retry_replay", 64'(s_replay), 64'd0);
    drive(0, 0, 0, '0, '0);
    step();
    chk("retry_cnt4", 64'(s_ccount), 64'd4);

    // Reset mid-operation; inputs during reset are ignored
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 32'(i + 1), 64'(i + 1));
      step();
    end
    drive(1, 1, 1, 32'h77, 64'h77);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, '0, '0);
    step();
    chk("midrst_valid", 64'({s_cvalid, s_xvalid}), 64'd0);
    chk("midrst_counts", 64'({s_ccount[7:0], s_xcount[7:0]}), 64'd0);
    drive(1, 1, 1, 32'h5, 64'h5);
    step();
    drive(0, 0, 0, '0, '0);
    step();
    chk("midrst_cbits", 64'(s_cbits), 64'h5);
    chk("midrst_xbits", s_xbits, 64'h5);

    // Drain, then wrap-around streaming with random drain patterns
    bus.io_cmdq_deq_ready = 1'b1;
    bus.io_ximm1q_deq_ready = 1'b1;
    step();
    idx = 0;
    for (int cyc = 0; cyc < 300 && got.size() < 10; cyc++) begin
      drive(idx < 10, 1, 0, 32'(idx), '0);
      bus.io_cmdq_deq_ready = 1'($urandom_range(0, 1));
      step();
      chk("wrap_count_le4", 64'(s_ccount <= CMDQ_DEPTH), 64'd1);
      if (s_cfire) got.push_back(int'(s_cbits));
      if (idx < 10 && !s_replay) idx++;
    end
    drive(0, 0, 0, '0, '0);
    chk("wrap_num", 64'(got.size()), 64'd10);
    for (int i = 0; i < got.size(); i++) chk("wrap_order", 64'(got[i]), 64'(i));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmd_ximm_issue_queues.md
Name: cmd_ximm_issue_queues

Overview:
- Downstream stage of the block decoder: consumes the decoder's `enq_cmdq` / `enq_ximm1q` signals.
- Owns two FIFOs, the command queue (cmdq) and the immediate queue (ximm1q), and enqueues into both atomically.
- Combinationally returns `io_replay` to the front end whenever a required queue cannot accept.
- The back end drains each queue independently through ready/valid ports.

Parameters:
- CMD_W, 32, width of a command word.
- XIMM_W, 64, width of an ximm1 immediate.
- CMDQ_DEPTH, 4, cmdq entries; power of two, >=2.
- XIMMQ_DEPTH, 4, ximm1q entries; power of two, >=2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_valid  in  1  decoder has an instruction this cycle.
- io_sigs_enq_cmdq  in  1  instruction requires a cmdq entry.
- io_sigs_enq_ximm1q  in  1  instruction requires an ximm1q entry.
- io_cmd  in  CMD_W  command payload.
- io_ximm1  in  XIMM_W  immediate payload.
- io_replay  out  1  instruction not accepted; front end must reissue.
- io_cmdq_deq_valid  out  1  cmdq head valid.
- io_cmdq_deq_ready  in  1  consumer takes cmdq head.
- io_cmdq_deq_bits  out  CMD_W  cmdq head data.
- io_ximm1q_deq_valid  out  1  ximm1q head valid.
- io_ximm1q_deq_ready  in  1  consumer takes ximm1q head.
- io_ximm1q_deq_bits  out  XIMM_W  ximm1q head data.
- io_cmdq_count  out  log2(CMDQ_DEPTH)+1  cmdq occupancy.
- io_ximm1q_count  out  log2(XIMMQ_DEPTH)+1  ximm1q occupancy.

Behaviour:
- **Ready definitions:** `cmdq_ready = !cmdq_full`; `ximm1q_ready = !ximm1q_full`. Ready depends only on registered state; a same-cycle dequeue does not free a slot for enqueue.
- **Replay:** `io_replay = io_valid & ((enq_cmdq & !cmdq_ready) | (enq_ximm1q & !ximm1q_ready))`. Purely combinational; zero latency.
- **Fire:** `fire = io_valid & !io_replay`.
- **Atomic enqueue:** on fire, cmdq writes `io_cmd` iff `enq_cmdq`, and ximm1q writes `io_ximm1` iff `enq_ximm1q`. Never a partial enqueue: if either required queue is full, neither queue is written.
- **No-op instruction:** valid with neither sig set fires with no writes and `io_replay = 0`.
- **Replay is registration-free:** the same instruction replayed later behaves identically.
- **Queue storage:** each queue is a circular buffer with head pointer, tail pointer and `maybe_full` bit.
  - empty = (head==tail) & !maybe_full.
  - full = (head==tail) & maybe_full.
  - Pointers wrap modulo DEPTH.
- **Dequeue:** fires on `deq_valid & deq_ready`; `deq_valid = !empty`; `deq_bits = mem[head]`.
- **No flow-through:** an entry enqueued in cycle N is visible at the deq port in cycle N+1.
- **maybe_full update:**
  - Set on enq without deq.
  - Cleared on deq without enq.
  - Unchanged on simultaneous enq/deq; both pointers advance.
- **Count:** count = (tail − head) mod DEPTH, or DEPTH when full. It updates the cycle after the enq/deq.
- **Ordering:** FIFO order is preserved per queue. The two queues are independent on the drain side.
- **Reset (synchronous, active-high):** head, tail, maybe_full = 0 in both queues.
  - Outputs after reset: `deq_valid = 0`, counts = 0.
  - `io_replay` follows inputs: empty queues never cause replay.
  - Reset mid-operation discards all entries; storage contents are don't-care and are never exposed while `deq_valid = 0`.
  - Inputs are ignored during a reset cycle: no writes occur.
- **Deq on empty:** `deq_ready` while empty is ignored; no pointer movement.

Decomposition:
- **Shared package:** CMD_W, XIMM_W and depth constants; a pointer-width function `log2(DEPTH)`.
- **Sub-module `issue_fifo`:** parameters WIDTH, DEPTH.
  - Ports: `clk`, `reset`, `enq_valid`, `enq_ready`, `enq_bits`, `deq_valid`, `deq_ready`, `deq_bits`, `count`.
  - Instantiated twice.
  - The top level holds only the replay/fire logic.

Test Plan:
- **Post-reset issue:** after reset, valid=1, enq_cmdq=1, enq_ximm1q=1, cmd=0x11, ximm1=0x22 → replay=0. Next cycle cmdq_deq_valid=1 with bits 0x11, ximm1q_deq_valid=1 with bits 0x22, both counts=1.
- **Atomicity:** fill ximm1q to 4 with deq_ready=0, then issue valid with both sigs → replay=1, and cmdq_count is unchanged (no partial write).
- **Non-blocking queue:** ximm1q full, issue enq_cmdq=1 only → replay=0, cmdq_count increments; no-op instruction (both sigs 0) → replay=0, counts unchanged.
- **Full with same-cycle drain:** cmdq full (count 4), enq_cmdq plus deq_ready=1 in the same cycle → replay=1, dequeue occurs, count=3. Next cycle the issue succeeds and count returns to 4.
- **Wrap-around ordering:** stream 10 commands 0..9 with simultaneous enq/deq at random ready patterns → deq order is exactly 0..9, and count never exceeds 4.
- **Reset mid-operation:** 3 entries in each queue, assert reset one cycle → following cycle deq_valid=0 on both and counts=0; the next enqueue of 0x5 emerges first.
